// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128 key schedule generator with valid/ready round-key output
//
// Emits round keys 0..10 of a 128-bit cipher key, computing one key per accepted
// handshake from the key currently on round_key.
//
// Optional feature macro: AES_KEYEXP_REVERSE_EN
//   When defined, start with dir=1 pre-computes all 11 keys into a key bank
//   (FILL state, rk_valid low) and then emits them in order 10 down to 0.
//   When undefined there is no bank and no FILL state, and dir is ignored.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    begin expansion of key_in (accepted only when idle)
//   key_in     in   128  cipher key, MSB = byte 0
//   dir        in   1    0 = rounds 0..10, 1 = rounds 10..0 (reverse build only)
//   rk_valid   out  1    round_key/round_idx hold a valid key
//   rk_ready   in   1    consumer accepts the key when high with rk_valid
//   round_key  out  128  current round key, MSB = byte 0
//   round_idx  out  4    round number of round_key, 0..10
//   busy       out  1    high whenever not idle
//   done       out  1    one-cycle pulse after the final key is accepted

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Row-major S-box table, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a sits at bit offset 8*(255-a), and 255-a == ~a for 8 bits.
    logic [10:0] bit_idx;
    assign bit_idx = {~a, 3'b000};
    assign y = SBOX[bit_idx +: 8];
endmodule

module aes_key_expander (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         dir,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);
`ifdef AES_KEYEXP_REVERSE_EN
    typedef enum logic [1:0] {IDLE, EMIT, FILL} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

    state_t      state;
    logic [7:0]  rcon;
    logic [7:0]  rcon_next;
    logic [127:0] next_key;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] t_word;
    logic [31:0] w0_n, w1_n, w2_n, w3_n;
    logic        handshake;

    assign handshake = rk_valid & rk_ready;

    // round_key doubles as the working register: the next key is always
    // derived from the key currently presented.
    assign rot_word = {round_key[23:0], round_key[31:24]};

    aes_sbox u_sbox0 (.a(rot_word[31:24]), .y(sub_word[31:24]));
    aes_sbox u_sbox1 (.a(rot_word[23:16]), .y(sub_word[23:16]));
    aes_sbox u_sbox2 (.a(rot_word[15:8]),  .y(sub_word[15:8]));
    aes_sbox u_sbox3 (.a(rot_word[7:0]),   .y(sub_word[7:0]));

    assign t_word   = sub_word ^ {rcon, 24'h000000};
    assign w0_n     = round_key[127:96] ^ t_word;
    assign w1_n     = round_key[95:64]  ^ w0_n;
    assign w2_n     = round_key[63:32]  ^ w1_n;
    assign w3_n     = round_key[31:0]   ^ w2_n;
    assign next_key = {w0_n, w1_n, w2_n, w3_n};

    // xtime in GF(2^8)
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

`ifdef AES_KEYEXP_REVERSE_EN
    logic         rev;
    logic [127:0] bank [0:10];
    logic         bank_we;
    logic [3:0]   bank_waddr;
    logic [127:0] bank_wdata;

    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = 4'd0;
        bank_wdata = key_in;
        if (state == IDLE && start && dir) begin
            bank_we    = 1'b1;
            bank_waddr = 4'd0;
            bank_wdata = key_in;
        end else if (state == FILL) begin
            bank_we    = 1'b1;
            bank_waddr = round_idx + 4'd1;
            bank_wdata = next_key;
        end
    end

    // Storage only; no reset needed since every entry is written before use.
    always_ff @(posedge clk) begin
        if (bank_we)
            bank[bank_waddr] <= bank_wdata;
    end
`else
    logic unused_dir;
    assign unused_dir = dir;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rk_valid  <= 1'b0;
            round_key <= 128'h0;
            round_idx <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rcon      <= 8'h01;
`ifdef AES_KEYEXP_REVERSE_EN
            rev       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rcon      <= 8'h01;
                        busy      <= 1'b1;
                        round_key <= key_in;
                        round_idx <= 4'd0;
`ifdef AES_KEYEXP_REVERSE_EN
                        rev       <= dir;
                        if (dir) begin
                            state <= FILL;
                        end else begin
                            rk_valid <= 1'b1;
                            state    <= EMIT;
                        end
`else
                        rk_valid  <= 1'b1;
                        state     <= EMIT;
`endif
                    end
                end
`ifdef AES_KEYEXP_REVERSE_EN
                FILL: begin
                    // Walk forward to key 10; it stays in round_key so the
                    // bank read path only serves keys 9..0.
                    round_key <= next_key;
                    rcon      <= rcon_next;
                    round_idx <= round_idx + 4'd1;
                    if (round_idx == 4'd9) begin
                        rk_valid <= 1'b1;
                        state    <= EMIT;
                    end
                end
`endif
                EMIT: begin
                    if (handshake) begin
`ifdef AES_KEYEXP_REVERSE_EN
                        if (rev) begin
                            if (round_idx == 4'd0) begin
                                rk_valid <= 1'b0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                round_key <= bank[round_idx - 4'd1];
                                round_idx <= round_idx - 4'd1;
                            end
                        end else
`endif
                        if (round_idx == 4'd10) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            round_key <= next_key;
                            round_idx <= round_idx + 4'd1;
                            rcon      <= rcon_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed self-checking bench for aes_key_expander
module tb_aes_key_expander;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         dir;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] fips [0:10];
    localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;

    always #5 clk = ~clk;

    aes_key_expander dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .dir(dir),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; dir = 1'b0; key_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue_start(input logic [127:0] k, input logic d);
        start = 1'b1; key_in = k; dir = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; rk_ready = 1'b1; dir = 1'b0; key_in = fips[0];
        @(negedge clk);
        @(negedge clk);
        if (rk_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", rk_valid); n_err++; end
        n_cmp++;
        if (round_key !== 128'h0) begin $display("FAIL reset_key got %h want 0", round_key); n_err++; end
        n_cmp++;
        if (round_idx !== 4'd0) begin $display("FAIL reset_idx got %0d want 0", round_idx); n_err++; end
        n_cmp++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_err++; end
        n_cmp++;
        if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); n_err++; end
        n_cmp++;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward;
        do_reset();
        rk_ready = 1'b1;
        issue_start(fips[0], 1'b0);
        if (busy !== 1'b1) begin $display("FAIL fwd_busy got %b want 1", busy); n_err++; end
        n_cmp++;
        for (int k = 0; k <= 10; k++) begin
            if (rk_valid !== 1'b1) begin $display("FAIL fwd_valid r%0d got %b want 1", k, rk_valid); n_err++; end
            n_cmp++;
            if (round_idx !== k[3:0]) begin $display("FAIL fwd_idx got %0d want %0d", round_idx, k); n_err++; end
            n_cmp++;
            if (round_key !== fips[k]) begin $display("FAIL fwd_key r%0d got %h want %h", k, round_key, fips[k]); n_err++; end
            n_cmp++;
            if (done !== 1'b0) begin $display("FAIL fwd_early_done r%0d got %b want 0", k, done); n_err++; end
            n_cmp++;
            @(negedge clk);
        end
        if (done !== 1'b1) begin $display("FAIL fwd_done_c12 got %b want 1", done); n_err++; end
        n_cmp++;
        if (busy !== 1'b0) begin $display("FAIL fwd_busy_end got %b want 0", busy); n_err++; end
        n_cmp++;
        if (rk_valid !== 1'b0) begin $display("FAIL fwd_valid_end got %b want 0", rk_valid); n_err++; end
        n_cmp++;
        @(negedge clk);
        if (done !== 1'b0) begin $display("FAIL fwd_done_pulse got %b want 0", done); n_err++; end
        n_cmp++;
    endtask

    task automatic test_stall;
        int exp_idx = 0;
        bit prev_stall = 1'b0;
        bit got_done = 1'b0;
        int cyc = 0;
        logic [127:0] saved_key = '0;
        logic [3:0] saved_idx = '0;
        int r;
        do_reset();
        rk_ready = 1'b0;
        issue_start(fips[0], 1'b0);
        while (!got_done && cyc < 200) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (exp_idx > 10) begin
                    $display("FAIL stall_extra_key got idx %0d want done", round_idx); n_err++;
                    n_cmp++;
                    exp_idx = 10;
                end
                if (rk_valid !== 1'b1) begin $display("FAIL stall_valid got %b want 1", rk_valid); n_err++; end
                n_cmp++;
                if (round_idx !== exp_idx[3:0]) begin $display("FAIL stall_idx got %0d want %0d", round_idx, exp_idx); n_err++; end
                n_cmp++;
                if (round_key !== fips[exp_idx]) begin $display("FAIL stall_key got %h want %h", round_key, fips[exp_idx]); n_err++; end
                n_cmp++;
                if (prev_stall) begin
                    if (round_key !== saved_key || round_idx !== saved_idx) begin
                        $display("FAIL stall_hold got %h/%0d want %h/%0d", round_key, round_idx, saved_key, saved_idx); n_err++;
                    end
                    n_cmp++;
                end
                saved_key = round_key;
                saved_idx = round_idx;
                r = $urandom_range(0, 1);
                rk_ready = r[0];
                prev_stall = !r[0];
                if (r[0]) exp_idx++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) begin $display("FAIL stall_timeout got no done want done"); n_err++; end
        n_cmp++;
        if (exp_idx !== 11) begin $display("FAIL stall_count got %0d want 11", exp_idx); n_err++; end
        n_cmp++;
        rk_ready = 1'b0;
    endtask

    task automatic test_ignore_start;
        do_reset();
        rk_ready = 1'b1;
        issue_start(fips[0], 1'b0);
        for (int k = 0; k <= 10; k++) begin
            if (round_idx !== k[3:0]) begin $display("FAIL ign_idx got %0d want %0d", round_idx, k); n_err++; end
            n_cmp++;
            if (round_key !== fips[k]) begin $display("FAIL ign_key r%0d got %h want %h", k, round_key, fips[k]); n_err++; end
            n_cmp++;
            if (k == 4) begin
                start = 1'b1; key_in = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (done !== 1'b1) begin $display("FAIL ign_done got %b want 1", done); n_err++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        rk_ready = 1'b1;
        issue_start(fips[0], 1'b0);
        repeat (6) @(negedge clk);
        if (round_idx !== 4'd6) begin $display("FAIL rmid_pre_idx got %0d want 6", round_idx); n_err++; end
        n_cmp++;
        rst_n = 1'b0;
        #1;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL rmid_flags got v%b b%b d%b want 000", rk_valid, busy, done); n_err++;
        end
        n_cmp++;
        if (round_key !== 128'h0) begin $display("FAIL rmid_key got %h want 0", round_key); n_err++; end
        n_cmp++;
        if (round_idx !== 4'd0) begin $display("FAIL rmid_idx got %0d want 0", round_idx); n_err++; end
        n_cmp++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_start(fips[0], 1'b0);
        @(negedge clk);
        if (round_idx !== 4'd1) begin $display("FAIL rmid_r1_idx got %0d want 1", round_idx); n_err++; end
        n_cmp++;
        if (round_key !== fips[1]) begin $display("FAIL rmid_r1_key got %h want %h", round_key, fips[1]); n_err++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        do_reset();
        rk_ready = 1'b1;
        issue_start(fips[0], 1'b0);
        while (done !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin $display("FAIL b2b_done_timeout got %b want 1", done); n_err++; end
        n_cmp++;
        issue_start(128'h0, 1'b0);
        if (rk_valid !== 1'b1) begin $display("FAIL b2b_valid got %b want 1", rk_valid); n_err++; end
        n_cmp++;
        if (round_idx !== 4'd0) begin $display("FAIL b2b_idx got %0d want 0", round_idx); n_err++; end
        n_cmp++;
        if (round_key !== 128'h0) begin $display("FAIL b2b_r0 got %h want 0", round_key); n_err++; end
        n_cmp++;
        if (busy !== 1'b1) begin $display("FAIL b2b_busy got %b want 1", busy); n_err++; end
        n_cmp++;
        @(negedge clk);
        if (round_key !== ZERO_R1) begin $display("FAIL b2b_r1 got %h want %h", round_key, ZERO_R1); n_err++; end
        n_cmp++;
    endtask

    task automatic test_dir;
        do_reset();
        rk_ready = 1'b1;
        issue_start(fips[0], 1'b1);
`ifdef AES_KEYEXP_REVERSE_EN
        if (rk_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL rev_fill got v%b b%b want v0 b1", rk_valid, busy); n_err++;
        end
        n_cmp++;
        repeat (9) @(negedge clk);
        if (rk_valid !== 1'b0) begin $display("FAIL rev_early_valid got %b want 0", rk_valid); n_err++; end
        n_cmp++;
        @(negedge clk);
        for (int k = 10; k >= 0; k--) begin
            if (rk_valid !== 1'b1) begin $display("FAIL rev_valid r%0d got %b want 1", k, rk_valid); n_err++; end
            n_cmp++;
            if (round_idx !== k[3:0]) begin $display("FAIL rev_idx got %0d want %0d", round_idx, k); n_err++; end
            n_cmp++;
            if (round_key !== fips[k]) begin $display("FAIL rev_key r%0d got %h want %h", k, round_key, fips[k]); n_err++; end
            n_cmp++;
            @(negedge clk);
        end
        if (done !== 1'b1) begin $display("FAIL rev_done got %b want 1", done); n_err++; end
        n_cmp++;
`else
        if (round_idx !== 4'd0) begin $display("FAIL dir_ign_idx got %0d want 0", round_idx); n_err++; end
        n_cmp++;
        if (round_key !== fips[0]) begin $display("FAIL dir_ign_r0 got %h want %h", round_key, fips[0]); n_err++; end
        n_cmp++;
        @(negedge clk);
        if (round_key !== fips[1]) begin $display("FAIL dir_ign_r1 got %h want %h", round_key, fips[1]); n_err++; end
        n_cmp++;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; dir = 1'b0; key_in = '0;

        test_reset();
        test_forward();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_dir();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
